// File: rtl/booth_pkg.sv
// Shared constants, FSM state encoding and the id-width helper for booth_mul_arbiter.
package booth_pkg;

  localparam int MWL      = 8;
  localparam int PWL      = 2 * MWL;
  localparam int NREQ_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    MUL2 = 2'd2,
    RESP = 2'd3
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_mul.sv
// BoothMUL: combinational radix-4 Booth signed multiplier, MWL x MWL -> 2*MWL (MWL even).
module BoothMUL #(
  parameter int MWL = 8,
  parameter int PWL = 2 * MWL
) (
  input  logic signed [MWL-1:0] x,
  input  logic signed [MWL-1:0] y,
  output logic signed [PWL-1:0] p
);

  logic        [MWL:0]   ybits;
  logic        [2:0]     trip;
  logic signed [PWL-1:0] xe;
  logic signed [PWL-1:0] pp;
  logic signed [PWL-1:0] acc;

  always_comb begin
    ybits = {y, 1'b0};
    xe    = PWL'(x);
    trip  = '0;
    pp    = '0;
    acc   = '0;
    // Each overlapping bit triplet of y selects 0, +-x or +-2x as a partial product.
    for (int i = 0; i < MWL / 2; i++) begin
      trip = ybits[2*i +: 3];
      unique case (trip)
        3'b001, 3'b010: pp = xe;
        3'b011:         pp = xe <<< 1;
        3'b100:         pp = -(xe <<< 1);
        3'b101, 3'b110: pp = -xe;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2 * i));
    end
    p = acc;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first valid requester after last_grant (mod NREQ).
module rr_arbiter
  import booth_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  int   idx;
  logic found;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && valid[idx[IDW-1:0]]) begin
        found                = 1'b1;
        grant[idx[IDW-1:0]]  = 1'b1;
        grant_id             = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sequencer sharing one BoothMUL among NREQ requesters.
// Define BOOTH_ARB_PIPE_EN to register the multiplier output in an extra MUL2 state.
module booth_mul_arbiter #(
  parameter  int NREQ = booth_pkg::NREQ_DEF,
  parameter  int MWL  = booth_pkg::MWL,
  parameter  int PWL  = booth_pkg::PWL,
  localparam int IDW  = booth_pkg::id_w(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*MWL-1:0]  req_x,
  input  logic [NREQ*MWL-1:0]  req_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [PWL-1:0]       rsp_p,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  booth_pkg::state_t     state;
  logic [IDW-1:0]        last_grant;
  logic [IDW-1:0]        grant_id;
  logic [NREQ-1:0]       grant;
  logic [IDW-1:0]        op_id;
  logic signed [MWL-1:0] op_x;
  logic signed [MWL-1:0] op_y;
  logic signed [PWL-1:0] prod;
`ifdef BOOTH_ARB_PIPE_EN
  logic signed [PWL-1:0] prod_q;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  BoothMUL #(.MWL(MWL), .PWL(PWL)) u_mul (
    .x (op_x),
    .y (op_y),
    .p (prod)
  );

  // Grant is offered only while arbitrating; it never depends on rsp_ready.
  assign req_ready = (state == booth_pkg::IDLE) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= booth_pkg::IDLE;
      last_grant <= IDW'(NREQ - 1);
      // NOTE: the operand/product registers are few and narrow, so they are reset with the
      // rest; this keeps rsp_p/rsp_id at known values after reset and any in-flight job is dropped.
      op_x       <= '0;
      op_y       <= '0;
      op_id      <= '0;
`ifdef BOOTH_ARB_PIPE_EN
      prod_q     <= '0;
`endif
      rsp_p      <= '0;
      rsp_id     <= '0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
      unique case (state)
        booth_pkg::IDLE: begin
          if (|req_valid) begin
            op_x       <= req_x[int'(grant_id) * MWL +: MWL];
            op_y       <= req_y[int'(grant_id) * MWL +: MWL];
            op_id      <= grant_id;
            last_grant <= grant_id;
            busy       <= 1'b1;
            state      <= booth_pkg::MUL;
          end
        end
        booth_pkg::MUL: begin
`ifdef BOOTH_ARB_PIPE_EN
          prod_q    <= prod;
          state     <= booth_pkg::MUL2;
`else
          rsp_p     <= prod;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= booth_pkg::RESP;
`endif
        end
`ifdef BOOTH_ARB_PIPE_EN
        booth_pkg::MUL2: begin
          rsp_p     <= prod_q;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= booth_pkg::RESP;
        end
`endif
        booth_pkg::RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= booth_pkg::IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= booth_pkg::IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational `BoothMUL` (signed 8x8 to 16) among `NREQ` requesters. Each requester hands over an operand pair with a valid/ready handshake. The block registers the operands and drives the shared multiplier. It then returns the registered product, tagged with the requester index, on a single valid/ready response channel. It sits between the client datapaths and the multiplier core, and it is the only instantiator of `BoothMUL` in the subsystem.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `MWL`, default 8: operand width; must equal the `BoothMUL` multiplicand width.
- `PWL`, default 16: product width, 2*`MWL`.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  `NREQ`: per-requester operand valid.
- `req_ready`  out  `NREQ`: per-requester accept; one-hot or zero.
- `req_x`  in  `NREQ*MWL`: multiplicands, signed two's complement; requester i at bits [i*MWL +: MWL].
- `req_y`  in  `NREQ*MWL`: multipliers, same packing as `req_x`.
- `rsp_valid`  out  1: product available.
- `rsp_ready`  in  1: response consumer accept.
- `rsp_p`  out  `PWL`: signed product X*Y.
- `rsp_id`  out  clog2(`NREQ`): index of the requester that owns `rsp_p`.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: arbitration only.
  - MUL: operands held, multiplier settling.
  - MUL2: exists only with the macro.
  - RESP: product held until consumed.
- IDLE: if any `req_valid` is high, the round-robin winner g is the first requester set at or after `last_grant+1`, searching modulo `NREQ`.
  - `req_ready[g]` = 1 in the same cycle, combinational from `req_valid`.
  - On that edge: latch `req_x[g]`, `req_y[g]` and g into the operand registers; set `last_grant` = g; go to MUL.
  - With no request, stay in IDLE.
- MUL: `BoothMUL` is driven from the operand registers. At the edge, the product is latched into `rsp_p` and the tag into `rsp_id`, then go to RESP (MUL2 with the macro).
- RESP: `rsp_valid` = 1, and `rsp_p`/`rsp_id` are stable. On the edge where `rsp_ready` = 1, go to IDLE.
- `req_ready` is all-zero outside IDLE. Requests that are not granted must hold their valid and data; the block never drops them.
- `last_grant` resets to `NREQ-1`, so requester 0 wins the first arbitration.
- Arithmetic: full signed range with no saturation. -128*-128 = 0x4000, -128*127 = 0xC080, 0*x = 0.
- Reset asserted mid-operation: the in-flight product is discarded, the FSM goes to IDLE, and no response is issued for it.

## Timing
- Reset values:
  - `req_ready` = 0
  - `rsp_valid` = 0
  - `rsp_p` = 0
  - `rsp_id` = 0
  - `busy` = 0
  - `last_grant` = `NREQ-1`
- Latency: the request handshake is at edge T. `rsp_valid` rises after edge T+1, or T+2 with the macro.
- Throughput: at most one operation per 3 cycles (4 with the macro), plus any cycles `rsp_ready` is held low.
- `rsp_ready` is sampled only in RESP. When it is already high on RESP entry, RESP lasts exactly one cycle.
- Returning to IDLE: arbitration happens in the first IDLE cycle. There is no bypass from RESP to grant.
- `req_ready` has a combinational path from `req_valid` and none from `rsp_ready`.

## Configuration
- `BOOTH_ARB_PIPE_EN` defined: adds state MUL2 and a product pipeline register.
  - The `BoothMUL` output is registered at the end of MUL.
  - It is copied to `rsp_p` at the end of MUL2.
  - This splits the multiplier path from the output register for timing closure. Latency +1 cycle.
- `BOOTH_ARB_PIPE_EN` undefined: MUL goes directly to RESP, and neither MUL2 nor the extra register exists.
- Functional results are identical either way.

## Structure
- Package `booth_pkg` holds:
  - constants `MWL`, `PWL` and default `NREQ`
  - the FSM state enum (IDLE, MUL, MUL2, RESP)
  - the id-width function (clog2 of `NREQ`)
- Sub-module `rr_arbiter`: combinational round-robin grant from the `req_valid` vector and `last_grant`, giving a one-hot grant and an encoded index. `last_grant` itself is held in `booth_mul_arbiter`.
- `BoothMUL` is instantiated once, unmodified.

## Test plan
- Single request, requester 2: X=0x05, Y=0xFD, `rsp_ready` tied high. Expect `rsp_p`=0xFFF1 and `rsp_id`=2, with `rsp_valid` for exactly 1 cycle at T+2 (T+3 with the macro).
- All 4 requesters valid continuously. Expect grants in order 0,1,2,3,0; each `req_ready` pulse is one cycle and one-hot.
- Corner operands: -128*-128 → 0x4000, -128*127 → 0xC080, 127*127 → 0x3F01, 0*-1 → 0x0000.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP. Expect `rsp_p`/`rsp_id` stable, `req_ready` all-zero and `busy`=1; IDLE on the cycle after `rsp_ready` rises.
- Reset asserted during MUL. Expect all outputs at reset values immediately. After release, a new request from requester 0 wins, and no stale response appears.
- Randomised 10k operations with random backpressure against a signed reference model. Checks: no lost or duplicated ids, and products match the model.
